apb_master_arbiter: RTL and testbench

- Two-requester APB master that shares one APB port to the I2C core's register file (paddr/pwdata/prdata/pselx/penable/pwrite/pready).
- Arbitrates round-robin between requesters (e.g. firmware bridge and the directed bench/command sequencer).
- Sequences the APB SETUP/ACCESS phases and returns read data, completion and error to the granted requester.
- Sits between the requesters and the I2C APB slave, in the pclk domain.

---
 rtl/apb_master_arbiter.sv | 149 ++++++++++++++
 tb/tb_apb_master_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_arbiter.sv
// Two-requester APB master for the I2C core register file.
// Round-robin arbitration between two requesters, APB SETUP/ACCESS
// sequencing, and per-requester completion, read data and timeout error.
module apb_master_arbiter #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic              pclk,
  input  logic              preset_n,
  // requester 0
  input  logic              req0_valid,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  output logic              req0_done,
  output logic [DATA_W-1:0] req0_rdata,
  output logic              req0_err,
  // requester 1
  input  logic              req1_valid,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              req1_done,
  output logic [DATA_W-1:0] req1_rdata,
  output logic              req1_err,
  // APB port
  output logic              pselx,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready
);

  // Counter only has to reach TIMEOUT-1; keep at least one bit.
  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             grant;        // requester offered the bus this cycle
  logic             last_grant;   // owner of the current/most recent transfer
  logic             accept;       // granted requester handshakes this edge
  logic             timeout_hit;
  logic [CNT_W-1:0] count;

  // Round-robin pick: a lone requester wins, a contest goes to the one not served last.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    grant = ~last_grant;
    if (req0_valid && !req1_valid)      grant = 1'b0;
    else if (req1_valid && !req0_valid) grant = 1'b1;
  end

  assign req0_ready  = (state == IDLE) && (grant == 1'b0);
  assign req1_ready  = (state == IDLE) && (grant == 1'b1);
  assign accept      = (state == IDLE) && (grant ? req1_valid : req0_valid);
  assign timeout_hit = (TIMEOUT != 0) && (count == CNT_LAST);

  // APB strobes decode straight from state so reset drops them immediately.
  assign pselx   = (state == SETUP) || (state == ACCESS);
  assign penable = (state == ACCESS);

  // State register.
  always_ff @(posedge pclk or negedge preset_n) begin
    // NOTE: sequential blocks use non-blocking assignments so every register samples pre-edge values.
    if (!preset_n) state <= IDLE;
    else           state <= state_next;
  end

  // Next-state: one SETUP cycle, ACCESS until pready or timeout.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = SETUP;
      SETUP:   state_next = ACCESS;
      ACCESS:  if (pready || timeout_hit) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Transfer capture, timeout counting and completion reporting to the owner.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      pwrite     <= 1'b0;
      paddr      <= '0;
      pwdata     <= '0;
      last_grant <= 1'b1;
      count      <= '0;
      req0_done  <= 1'b0;
      req0_err   <= 1'b0;
      req0_rdata <= '0;
      req1_done  <= 1'b0;
      req1_err   <= 1'b0;
      req1_rdata <= '0;
    end else begin
      // done/err are single-cycle pulses unless set below.
      req0_done <= 1'b0;
      req0_err  <= 1'b0;
      req1_done <= 1'b0;
      req1_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            pwrite     <= grant ? req1_write : req0_write;
            paddr      <= grant ? req1_addr  : req0_addr;
            pwdata     <= grant ? req1_wdata : req0_wdata;
            last_grant <= grant;
            count      <= '0;
          end
        end
        ACCESS: begin
          if (pready) begin
            if (!last_grant) begin
              req0_done <= 1'b1;
              if (!pwrite) req0_rdata <= prdata;
            end else begin
              req1_done <= 1'b1;
              if (!pwrite) req1_rdata <= prdata;
            end
          end else begin
            count <= count + 1'b1;
            if (timeout_hit) begin
              if (!last_grant) begin
                req0_done <= 1'b1;
                req0_err  <= 1'b1;
              end else begin
                req1_done <= 1'b1;
                req1_err  <= 1'b1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Self-checking bench for apb_master_arbiter: APB slave model, done monitor
// and a transaction-level expectation of grant order, latency and data.
module tb_apb_master_arbiter;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int TO = 16;

  logic          pclk = 1'b0;
  logic          preset_n;
  logic          req0_valid, req0_write, req0_ready, req0_done, req0_err;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_wdata, req0_rdata;
  logic          req1_valid, req1_write, req1_ready, req1_done, req1_err;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_wdata, req1_rdata;
  logic          pselx, penable, pwrite, pready;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata, prdata;

  apb_master_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .pclk(pclk), .preset_n(preset_n),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ready(req0_ready), .req0_done(req0_done),
    .req0_rdata(req0_rdata), .req0_err(req0_err),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ready(req1_ready), .req1_done(req1_done),
    .req1_rdata(req1_rdata), .req1_err(req1_err),
    .pselx(pselx), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .prdata(prdata), .pready(pready)
  );

  always #5 pclk = ~pclk;

  typedef struct { int n; logic w; logic [7:0] a; logic [7:0] d; int cyc; } acc_t;
  typedef struct { logic w; logic [7:0] a; logic [7:0] d; logic [7:0] r; } apb_t;
  typedef struct { int n; logic err; logic [7:0] r; int cyc; } done_t;

  acc_t  acc_q[$];
  apb_t  apb_q[$];
  done_t done_q[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int wait_cycles = 0;   // low-pready ACCESS cycles before the slave answers
  int rd_value    = -1;  // fixed read data, or random when negative
  int acc_cnt     = 0;   // ACCESS cycles seen in the most recent transfer
  logic [7:0] model_rdata [2];

  always @(posedge pclk) cyc++;

  // APB slave model: answers after wait_cycles low cycles and logs the transfer.
  always @(negedge pclk) begin
    if (pselx && !penable) acc_cnt = 0;
    if (pselx && penable) begin
      if (acc_cnt == wait_cycles) begin
        pready = 1'b1;
        prdata = (rd_value < 0) ? 8'($urandom) : 8'(rd_value);
        apb_q.push_back('{pwrite, paddr, pwdata, prdata});
      end else begin
        pready = 1'b0;
      end
      acc_cnt++;
    end else begin
      pready = 1'b0;
    end
  end

  // Completion monitor.
  always @(negedge pclk) begin
    if (req0_done) done_q.push_back('{0, req0_err, req0_rdata, cyc});
    if (req1_done) done_q.push_back('{1, req1_err, req1_rdata, cyc});
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic set_req(input int n, input logic v, input logic w,
                         input logic [7:0] a, input logic [7:0] d);
    if (n == 0) begin
      req0_valid = v; req0_write = w; req0_addr = a; req0_wdata = d;
    end else begin
      req1_valid = v; req1_write = w; req1_addr = a; req1_wdata = d;
    end
  endtask

  task automatic clear_logs;
    acc_q.delete(); apb_q.delete(); done_q.delete();
  endtask

  task automatic do_reset;
    preset_n = 1'b0;
    set_req(0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0);
    repeat (2) @(negedge pclk);
    preset_n = 1'b1;
    model_rdata[0] = 8'h00;
    model_rdata[1] = 8'h00;
    @(negedge pclk);
  endtask

  // Requester driver: cnt transfers, mode 0=writes 1=reads 2=random; valid held until ready.
  task automatic drive(input int n, input int cnt, input int mode);
    for (int k = 0; k < cnt; k++) begin
      logic w;
      logic [7:0] a, d;
      int t;
      w = (mode == 2) ? 1'($urandom) : (mode == 0);
      a = 8'($urandom);
      d = 8'($urandom);
      t = 0;
      set_req(n, 1'b1, w, a, d);
      #1;
      while (!((n == 0) ? req0_ready : req1_ready)) begin
        @(negedge pclk); #1;
        t++;
        if (t > 200) begin
          total++; bad++;
          $display("FAIL drive_ready_req%0d got=no_ready want=ready", n);
          set_req(n, 0, 0, 0, 0);
          return;
        end
      end
      acc_q.push_back('{n, w, a, d, cyc + 1});
      @(posedge pclk);
      @(negedge pclk);
    end
    set_req(n, 0, 0, 0, 0);
  endtask

  task automatic test_reset;
    preset_n = 1'b0;
    set_req(0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0);
    repeat (2) @(negedge pclk);
    total++; if ({pselx, penable, pwrite} !== 3'b000) begin bad++; $display("FAIL reset_strobes got=%b want=000", {pselx, penable, pwrite}); end
    total++; if (paddr !== 8'h00) begin bad++; $display("FAIL reset_paddr got=%h want=00", paddr); end
    total++; if (pwdata !== 8'h00) begin bad++; $display("FAIL reset_pwdata got=%h want=00", pwdata); end
    total++; if ({req0_done, req0_err, req1_done, req1_err} !== 4'b0000) begin bad++; $display("FAIL reset_done_err got=%b want=0000", {req0_done, req0_err, req1_done, req1_err}); end
    total++; if ({req0_rdata, req1_rdata} !== 16'h0000) begin bad++; $display("FAIL reset_rdata got=%h want=0000", {req0_rdata, req1_rdata}); end
    preset_n = 1'b1;
    model_rdata[0] = 8'h00;
    model_rdata[1] = 8'h00;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    total++; if ({req0_ready, req1_ready} !== 2'b10) begin bad++; $display("FAIL reset_first_contest got=%b want=10", {req0_ready, req1_ready}); end
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge pclk);
  endtask

  task automatic test_write_zero_wait;
    clear_logs();
    wait_cycles = 0;
    @(negedge pclk);
    set_req(0, 1'b1, 1'b1, 8'h02, 8'hA5);
    #1;
    total++; if (req0_ready !== 1'b1) begin bad++; $display("FAIL wr_ready got=%b want=1", req0_ready); end
    @(posedge pclk); @(negedge pclk);
    set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
    total++; if ({pselx, penable, pwrite, paddr, pwdata} !== {3'b101, 8'h02, 8'hA5})
      begin bad++; $display("FAIL wr_setup got=%b_%h_%h want=101_02_a5", {pselx, penable, pwrite}, paddr, pwdata); end
    @(negedge pclk);
    total++; if ({pselx, penable} !== 2'b11) begin bad++; $display("FAIL wr_access got=%b want=11", {pselx, penable}); end
    @(negedge pclk);
    total++; if ({req0_done, req0_err, req1_done, pselx, penable} !== 5'b10000)
      begin bad++; $display("FAIL wr_done got=%b want=10000", {req0_done, req0_err, req1_done, pselx, penable}); end
    @(negedge pclk);
    total++; if (req0_done !== 1'b0) begin bad++; $display("FAIL wr_done_pulse got=%b want=0", req0_done); end
  endtask

  task automatic test_read_wait;
    bit seen_done, seen_other, addr_ok;
    int t;
    clear_logs();
    wait_cycles = 3;
    rd_value = 8'h3C;
    seen_done = 0; seen_other = 0; addr_ok = 1;
    @(negedge pclk);
    set_req(1, 1'b1, 1'b0, 8'h04, 8'($urandom));
    #1;
    total++; if (req1_ready !== 1'b1) begin bad++; $display("FAIL rd_ready got=%b want=1", req1_ready); end
    @(posedge pclk); @(negedge pclk);
    set_req(1, 1'b0, 1'b0, 8'h00, 8'h00);
    t = 0;
    while (!seen_done && t < 40) begin
      // Idle requester 0 toggles its fields; the APB address must not follow.
      req0_addr = 8'($urandom); req0_wdata = 8'($urandom);
      @(negedge pclk);
      if (pselx && paddr !== 8'h04) addr_ok = 0;
      if (req1_done) seen_done = 1;
      if (req0_done) seen_other = 1;
      t++;
    end
    total++; if (!seen_done) begin bad++; $display("FAIL rd_done got=none want=pulse"); end
    total++; if ({req1_rdata, req1_err} !== {8'h3C, 1'b0}) begin bad++; $display("FAIL rd_data got=%h/%b want=3c/0", req1_rdata, req1_err); end
    total++; if (acc_cnt !== 4) begin bad++; $display("FAIL rd_penable_cycles got=%0d want=4", acc_cnt); end
    total++; if (!addr_ok) begin bad++; $display("FAIL rd_paddr_hold got=changed want=04"); end
    total++; if (seen_other || req0_rdata !== model_rdata[0]) begin bad++; $display("FAIL rd_req0_untouched got=%b/%h want=0/%h", seen_other, req0_rdata, model_rdata[0]); end
    model_rdata[1] = 8'h3C;
    rd_value = -1;
    @(negedge pclk);
  endtask

  task automatic test_contention;
    int rem [2];
    int last, exp_n, w;
    clear_logs();
    do_reset();
    w = $urandom_range(0, 2);
    wait_cycles = w;
    fork
      drive(0, 4, 2);
      drive(1, 4, 2);
    join
    repeat (8) @(negedge pclk);
    total++;
    if (acc_q.size() != 8 || apb_q.size() != 8 || done_q.size() != 8) begin
      bad++;
      $display("FAIL cont_counts got=%0d/%0d/%0d want=8/8/8", acc_q.size(), apb_q.size(), done_q.size());
    end else begin
      rem[0] = 4; rem[1] = 4; last = 1;
      for (int i = 0; i < 8; i++) begin
        if (rem[0] > 0 && rem[1] > 0) exp_n = 1 - last;
        else exp_n = (rem[0] > 0) ? 0 : 1;
        rem[exp_n]--; last = exp_n;
        total++; if (acc_q[i].n != exp_n) begin bad++; $display("FAIL cont_grant[%0d] got=%0d want=%0d", i, acc_q[i].n, exp_n); end
        total++; if (acc_q[i].cyc != acc_q[0].cyc + i * (3 + w)) begin bad++; $display("FAIL cont_spacing[%0d] got=%0d want=%0d", i, acc_q[i].cyc - acc_q[0].cyc, i * (3 + w)); end
        total++; if ({apb_q[i].w, apb_q[i].a, apb_q[i].d} !== {acc_q[i].w, acc_q[i].a, acc_q[i].d} && (acc_q[i].w || apb_q[i].a !== acc_q[i].a || apb_q[i].w !== 1'b0))
          begin bad++; $display("FAIL cont_apb[%0d] got=%b_%h_%h want=%b_%h_%h", i, apb_q[i].w, apb_q[i].a, apb_q[i].d, acc_q[i].w, acc_q[i].a, acc_q[i].d); end
        if (!acc_q[i].w) model_rdata[acc_q[i].n] = apb_q[i].r;
        total++; if (done_q[i].n != acc_q[i].n || done_q[i].err !== 1'b0 || done_q[i].r !== model_rdata[acc_q[i].n] || done_q[i].cyc != acc_q[i].cyc + 2 + w)
          begin bad++; $display("FAIL cont_done[%0d] got=req%0d/%b/%h/+%0d want=req%0d/0/%h/+%0d", i, done_q[i].n, done_q[i].err, done_q[i].r, done_q[i].cyc - acc_q[i].cyc, acc_q[i].n, model_rdata[acc_q[i].n], 2 + w); end
      end
    end
  endtask

  task automatic test_timeout;
    clear_logs();
    wait_cycles = 1000;
    drive(0, 1, 1);
    repeat (TO + 4) @(negedge pclk);
    total++; if (acc_cnt !== TO) begin bad++; $display("FAIL to_penable_cycles got=%0d want=%0d", acc_cnt, TO); end
    total++;
    if (done_q.size() != 1 || acc_q.size() != 1) begin
      bad++; $display("FAIL to_done_count got=%0d want=1", done_q.size());
    end else if (done_q[0].n != 0 || done_q[0].err !== 1'b1 || done_q[0].r !== model_rdata[0] || done_q[0].cyc != acc_q[0].cyc + 1 + TO) begin
      bad++; $display("FAIL to_done got=req%0d/%b/%h/+%0d want=req0/1/%h/+%0d", done_q[0].n, done_q[0].err, done_q[0].r, done_q[0].cyc - acc_q[0].cyc, model_rdata[0], 1 + TO);
    end
    total++; if ({pselx, penable} !== 2'b00) begin bad++; $display("FAIL to_strobes got=%b want=00", {pselx, penable}); end
    clear_logs();
    wait_cycles = 0;
    drive(0, 1, 0);
    repeat (4) @(negedge pclk);
    total++; if (done_q.size() != 1 || done_q[0].err !== 1'b0 || done_q[0].n != 0)
      begin bad++; $display("FAIL to_recover got=%0d pulses want=1 ok pulse", done_q.size()); end
  endtask

  task automatic test_reset_mid_access;
    int t;
    clear_logs();
    wait_cycles = 1000;
    drive(1, 1, 1);
    t = 0;
    while (!penable && t < 5) begin @(negedge pclk); t++; end
    total++; if (penable !== 1'b1) begin bad++; $display("FAIL rst_reach_access got=%b want=1", penable); end
    repeat (2) @(negedge pclk);
    #2 preset_n = 1'b0;
    #1;
    total++; if ({pselx, penable, paddr} !== {2'b00, 8'h00}) begin bad++; $display("FAIL rst_async got=%b_%h want=00_00", {pselx, penable}, paddr); end
    done_q.delete();
    model_rdata[0] = 8'h00; model_rdata[1] = 8'h00;
    repeat (2) @(negedge pclk);
    preset_n = 1'b1;
    repeat (3) @(negedge pclk);
    total++; if (done_q.size() != 0) begin bad++; $display("FAIL rst_no_done got=%0d want=0", done_q.size()); end
    clear_logs();
    wait_cycles = 0;
    fork
      drive(0, 1, 2);
      drive(1, 1, 2);
    join
    repeat (5) @(negedge pclk);
    total++; if (acc_q.size() != 2 || acc_q[0].n != 0) begin bad++; $display("FAIL rst_first_grant got=%0d entries want=req0 first", acc_q.size()); end
  endtask

  task automatic test_back_to_back;
    clear_logs();
    wait_cycles = 0;
    drive(1, 3, 0);
    repeat (4) @(negedge pclk);
    total++;
    if (acc_q.size() != 3 || apb_q.size() != 3 || done_q.size() != 3) begin
      bad++; $display("FAIL b2b_counts got=%0d/%0d/%0d want=3/3/3", acc_q.size(), apb_q.size(), done_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        total++; if (acc_q[i].n != 1 || acc_q[i].cyc != acc_q[0].cyc + 3 * i) begin bad++; $display("FAIL b2b_accept[%0d] got=req%0d/+%0d want=req1/+%0d", i, acc_q[i].n, acc_q[i].cyc - acc_q[0].cyc, 3 * i); end
        total++; if ({apb_q[i].w, apb_q[i].a, apb_q[i].d} !== {1'b1, acc_q[i].a, acc_q[i].d}) begin bad++; $display("FAIL b2b_apb[%0d] got=%b_%h_%h want=1_%h_%h", i, apb_q[i].w, apb_q[i].a, apb_q[i].d, acc_q[i].a, acc_q[i].d); end
        total++; if (done_q[i].n != 1 || done_q[i].err !== 1'b0 || done_q[i].r !== model_rdata[1]) begin bad++; $display("FAIL b2b_done[%0d] got=req%0d/%b/%h want=req1/0/%h", i, done_q[i].n, done_q[i].err, done_q[i].r, model_rdata[1]); end
      end
    end
  endtask

  initial begin
    pready = 1'b0;
    prdata = 8'h00;
    test_reset();
    test_write_zero_wait();
    test_read_wait();
    test_contention();
    test_timeout();
    test_back_to_back();
    test_reset_mid_access();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
